// File: rtl/bsort_pkg.sv
// rtl/bsort_pkg.sv - shared types and defaults for the bubble-sort sequencer
package bsort_pkg;

    localparam int N_DEF  = 8;
    localparam int DW_DEF = 8;
    localparam int IW_DEF = 3;
    localparam int SCW    = 8;

    localparam logic [SCW-1:0] SWAP_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/bsort_pair_cnt.sv
// rtl/bsort_pair_cnt.sv - compare-pair index counter with a bound that shrinks each pass
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clr           load j=0, bound=N-2 (first pass of a job)
//   en            advance one compare
//   j             current pair low index
//   pass_end      j has reached the bound: this compare closes the pass
//   last_pass     bound is 0: only pair (0,1) is left
module bsort_pair_cnt #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] j,
    output logic          pass_end,
    output logic          last_pass
);

    logic [IW-1:0] bound;

    assign pass_end  = (j == bound);
    assign last_pass = (bound == '0);

    // After the final pass the bound may wrap; the controller leaves SORT
    // on that compare, and clr re-seeds before the next job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            j     <= '0;
            bound <= '0;
        end else if (clr) begin
            j     <= '0;
            bound <= IW'(N - 2);
        end else if (en) begin
            if (pass_end) begin
                j     <= '0;
                bound <= bound - IW'(1);
            end else begin
                j <= j + IW'(1);
            end
        end
    end

endmodule

// File: rtl/bsort_seq_ctrl.sv
// rtl/bsort_seq_ctrl.sv - load / bubble-sort / drain sequencer for the 8-entry sort datapath
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        begin a job (IDLE only, and not on the done cycle)
//   in_valid/in_data/in_ready    operand load stream
//   out_valid/out_data/out_ready sorted operand stream (out_data = rf_rdata)
//   rf_we/rf_waddr/rf_wdata      register-file load write port
//   cmp_en/a_idx/b_idx           compare-swap pair select and write-back enable
//   swap                         compare result rf[a_idx] > rf[b_idx]
//   rf_rdata                     register-file async read at a_idx
//   busy, done                   job in progress, one-cycle end-of-job pulse
//   pass_cnt, swap_cnt           job statistics, held in IDLE until next start
module bsort_seq_ctrl
    import bsort_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    input  logic           out_ready,
    output logic           rf_we,
    output logic [IW-1:0]  rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic           cmp_en,
    output logic [IW-1:0]  a_idx,
    output logic [IW-1:0]  b_idx,
    input  logic           swap,
    input  logic [DW-1:0]  rf_rdata,
    output logic           busy,
    output logic           done,
    output logic [IW-1:0]  pass_cnt,
    output logic [SCW-1:0] swap_cnt
);

    state_t         state, state_nxt;
    logic [IW-1:0]  ld_idx;
    logic [IW-1:0]  k;
    logic [IW-1:0]  j;
    logic           dirty;
    logic           done_q;
    logic [IW-1:0]  pass_cnt_q;
    logic [SCW-1:0] swap_cnt_q;
    logic           pass_end;
    logic           last_pass;

    logic start_go, load_last, sort_exit, out_accept, drain_last;

    // A start arriving together with done is dropped: the job that just
    // finished owns that cycle.
    assign start_go   = (state == ST_IDLE) && start && !done_q;
    assign load_last  = (state == ST_LOAD) && in_valid && (ld_idx == IW'(N - 1));
    // swap is folded in so a swap on the closing compare keeps the pass dirty.
    assign sort_exit  = (state == ST_SORT) && pass_end && (!(dirty || swap) || last_pass);
    assign out_accept = (state == ST_DRAIN) && out_ready;
    assign drain_last = out_accept && (k == IW'(N - 1));

    bsort_pair_cnt #(.N(N), .IW(IW)) u_pair_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (state == ST_LOAD),
        .en        (state == ST_SORT),
        .j         (j),
        .pass_end  (pass_end),
        .last_pass (last_pass)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_go)   state_nxt = ST_LOAD;
            ST_LOAD:  if (load_last)  state_nxt = ST_SORT;
            ST_SORT:  if (sort_exit)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        cmp_en    = 1'b0;
        a_idx     = '0;
        b_idx     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                rf_we    = in_valid;
                rf_waddr = ld_idx;
                rf_wdata = in_data;
                busy     = 1'b1;
            end
            ST_SORT: begin
                cmp_en = 1'b1;
                a_idx  = j;
                b_idx  = j + IW'(1);
                busy   = 1'b1;
            end
            ST_DRAIN: begin
                a_idx     = k;
                out_valid = 1'b1;
                out_data  = rf_rdata;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_idx     <= '0;
            k          <= '0;
            dirty      <= 1'b0;
            done_q     <= 1'b0;
            pass_cnt_q <= '0;
            swap_cnt_q <= '0;
        end else begin
            done_q <= drain_last;

            if (start_go) begin
                ld_idx     <= '0;
                pass_cnt_q <= '0;
                swap_cnt_q <= '0;
            end

            if (state == ST_LOAD) begin
                dirty <= 1'b0;
                k     <= '0;
                if (in_valid) begin
                    ld_idx <= ld_idx + IW'(1);
                end
            end

            if (state == ST_SORT) begin
                if (swap && (swap_cnt_q != SWAP_CNT_MAX)) begin
                    swap_cnt_q <= swap_cnt_q + SCW'(1);
                end
                if (pass_end) begin
                    pass_cnt_q <= pass_cnt_q + IW'(1);
                    dirty      <= 1'b0;
                end else if (swap) begin
                    dirty <= 1'b1;
                end
            end

            if (out_accept) begin
                k <= k + IW'(1);
            end
        end
    end

    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;
    assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_bsort_seq_ctrl.sv
// tb/tb_bsort_seq_ctrl.sv - self-checking bench for bsort_seq_ctrl with a register-file model
module tb_bsort_seq_ctrl;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, rf_we, cmp_en, swap, busy, done;
    logic [DW-1:0] out_data, rf_wdata, rf_rdata;
    logic [IW-1:0] rf_waddr, a_idx, b_idx, pass_cnt;
    logic [7:0]    swap_cnt;

    logic [DW-1:0] rf [N] = '{default: '0};

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] job_vals [N];
    logic [DW-1:0] exp_sorted [N];
    int exp_passes, exp_swaps, exp_cyc;

    always #5 clk = ~clk;

    bsort_seq_ctrl #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .cmp_en    (cmp_en),
        .a_idx     (a_idx),
        .b_idx     (b_idx),
        .swap      (swap),
        .rf_rdata  (rf_rdata),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .swap_cnt  (swap_cnt)
    );

    // Datapath model: register file with compare-swap write-back. The compare
    // result is driven every cycle so a controller that counts it outside SORT
    // is exposed.
    assign swap     = rf[a_idx] > rf[b_idx];
    assign rf_rdata = rf[a_idx];

    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (cmp_en && swap) begin
            rf[a_idx] <= rf[b_idx];
            rf[b_idx] <= rf[a_idx];
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sorted list plus bubble-sort pass/swap/compare counts.
    task automatic build_model();
        int a [N];
        int t, d;
        logic [DW-1:0] q [$];
        q = {};
        for (int i = 0; i < N; i++) begin
            q.push_back(job_vals[i]);
            a[i] = int'(job_vals[i]);
        end
        q.sort();
        for (int i = 0; i < N; i++) exp_sorted[i] = q[i];
        exp_passes = 0;
        exp_swaps  = 0;
        exp_cyc    = 0;
        for (int b = N - 2; b >= 0; b--) begin
            d = 0;
            for (int jj = 0; jj <= b; jj++) begin
                exp_cyc++;
                if (a[jj] > a[jj + 1]) begin
                    t = a[jj]; a[jj] = a[jj + 1]; a[jj + 1] = t;
                    exp_swaps++;
                    d = 1;
                end
            end
            exp_passes++;
            if (d == 0) break;
        end
        if (exp_swaps > 255) exp_swaps = 255;
    endtask

    task automatic run_job(input bit gaps, input bit rnd_stall, input int stall_at,
                           input bit spam, input bit chk_lat);
        int li, oi, sortc, stalls, first_acc, done_cyc;
        bit fin, held;
        logic [DW-1:0] held_data;
        build_model();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("idle_busy", 32'(busy), 0);
        li = 0; oi = 0; sortc = 0; stalls = 0; first_acc = -1; done_cyc = -1;
        fin = 1'b0; held = 1'b0; held_data = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            fin      = (oi == N);
            start    = fin ? 1'b1 : (spam ? ($urandom_range(0, 3) == 0) : 1'b0);
            in_valid = (li < N) ? (gaps ? ($urandom_range(0, 2) != 0) : 1'b1)
                                : (spam ? 1'($urandom_range(0, 1)) : 1'b0);
            in_data  = (li < N) ? job_vals[li] : 8'($urandom);
            if (stall_at >= 0) out_ready = !(oi == stall_at && stalls < 3);
            else out_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("in_ready", 32'(in_ready), 32'(li < N));
            chk("rf_we", 32'(rf_we), 32'(in_valid && li < N));
            if (rf_we) chk("rf_waddr", 32'(rf_waddr), li);
            chk("busy", 32'(busy), 32'(oi < N));
            chk("done", 32'(done), 32'(fin));
            if (cmp_en) begin
                sortc++;
                chk("b_idx", 32'(b_idx), 32'(a_idx) + 1);
            end
            if (out_valid && held) chk("out_stable", 32'(out_data), 32'(held_data));
            if (out_valid && out_ready && oi < N) begin
                chk("out_data", 32'(out_data), 32'(exp_sorted[oi]));
                oi++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_data = out_data;
                stalls++;
            end
            if (in_valid && li < N) begin
                if (first_acc < 0) first_acc = c;
                li++;
            end
            if (fin) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) chk("timeout", 0, 1);
        chk("sort_cycles", sortc, exp_cyc);
        chk("pass_cnt", 32'(pass_cnt), exp_passes);
        chk("swap_cnt", 32'(swap_cnt), exp_swaps);
        if (chk_lat) chk("latency", done_cyc - first_acc, 2 * N + exp_cyc);
        if (stall_at >= 0) chk("stall_cycles", stalls, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk("post_busy", 32'(busy), 0);
            chk("post_done", 32'(done), 0);
            chk("post_rf_we", 32'(rf_we), 0);
            chk("hold_pass_cnt", 32'(pass_cnt), exp_passes);
            chk("hold_swap_cnt", 32'(swap_cnt), exp_swaps);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int nc;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_cmp_en", 32'(cmp_en), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_swap_cnt", 32'(swap_cnt), 0);
        reset_n = 1'b1;

        // Reset in the middle of SORT on a descending load.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(N - 1 - i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        nc = 0;
        for (int c = 0; c < 40 && nc < 10; c++) begin
            #1 if (cmp_en) nc++;
            @(negedge clk);
        end
        #1;
        chk("pre_rst_swaps", 32'(swap_cnt), 10);
        chk("pre_rst_passes", 32'(pass_cnt), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pass_cnt", 32'(pass_cnt), 0);
        chk("midrst_swap_cnt", 32'(swap_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("after_rst_busy", 32'(busy), 0);
            chk("after_rst_done", 32'(done), 0);
        end

        for (int i = 0; i < N; i++) job_vals[i] = 8'(i);
        run_job(1'b0, 1'b0, -1, 1'b0, 1'b1);

        for (int i = 0; i < N; i++) job_vals[i] = 8'(N - 1 - i);
        run_job(1'b0, 1'b0, -1, 1'b0, 1'b1);

        job_vals = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd8, 8'd0, 8'd2, 8'd9};
        run_job(1'b1, 1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) job_vals[i] = 8'($urandom);
        run_job(1'b0, 1'b0, 2, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) job_vals[i] = 8'd3;
        run_job(1'b0, 1'b0, -1, 1'b1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) job_vals[i] = 8'($urandom_range(0, 15));
            run_job(1'b1, 1'b1, -1, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
